tmds_delay_ctrl: RTL and testbench
==================================

TMDS_DELAY_CTRL -- requirements
Module: tmds_delay_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 4: number of TMDS lanes, [3]=clock [2]=red [1]=green [0]=blue.
REQ-002 SHALL have parameter TAP_W, default 7: tap index width; DELAYF provides 128 steps.
REQ-003 SHALL have parameter HOLD, default 2, range 1..15: cycles per DIRECTION setup, MOVE high and MOVE low phase.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_shift  in  1  rising-edge clock; rst_n  in  1  async assert, sync deassert.
REQ-005 SHALL have cmd_valid  in  1  command request.
REQ-006 SHALL have cmd_ready  out  1  command accepted when valid and ready are both high.
REQ-007 SHALL have cmd_zero  in  1  1 = zero all lanes via loadn; lane and tap are ignored.
REQ-008 SHALL have cmd_lane  in  2  target lane.
REQ-009 SHALL have cmd_tap  in  TAP_W  target tap.
REQ-010 SHALL have move  out  LANES  per-lane DELAYF MOVE.
REQ-011 SHALL have loadn  out  1  shared DELAYF LOADN, active low.
REQ-012 SHALL have dir  out  1  shared DELAYF DIRECTION: 0 = increase, 1 = decrease.
REQ-013 SHALL have tap_cur  out  LANES*TAP_W  tracked tap per lane; lane i is at bits [i*TAP_W +: TAP_W].
REQ-014 SHALL have done  out  1  one-cycle pulse when a command completes.

Function
REQ-015 FSM states SHALL be INIT, IDLE, SETUP, PULSE, RECOVER, LOAD, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; commands are not queued.
REQ-017 On accept with cmd_zero=1, the FSM SHALL go to LOAD.
REQ-018 On accept with cmd_tap equal to the lane's tap_cur, the FSM SHALL go to DONE; no MOVE pulse is issued.
REQ-019 On accept with cmd_tap different from tap_cur, the FSM SHALL latch lane and target, set dir = (target < tap_cur), and go to SETUP.
REQ-020 SETUP SHALL last HOLD cycles with move all 0 and dir stable.
REQ-021 PULSE SHALL last HOLD cycles with only move[lane]=1.
REQ-022 RECOVER SHALL last HOLD cycles with move all 0.
REQ-023 On RECOVER exit, tap_cur[lane] SHALL step by ±1 per dir; the FSM goes to SETUP if still unequal to target, else DONE.
REQ-024 dir SHALL hold its value from SETUP entry through RECOVER exit and SHALL never change while any move bit is 1.
REQ-025 LOAD SHALL hold loadn=0 for HOLD cycles, then RECOVER-length idle, then set all tap_cur to 0 and go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 Latency SHALL be N*3*HOLD+1 cycles from accept to done for an N-step command, and 1 cycle for a no-op command.
REQ-028 tap_cur arithmetic SHALL be unsigned TAP_W bits and SHALL never wrap, since the target is always in range.
REQ-029 cmd_lane >= LANES SHALL be treated as a no-op completion (DONE, no pulses).

Reset
REQ-030 In reset: move=0, loadn=1, dir=0, done=0, cmd_ready=0, tap_cur all 0, state=INIT.
REQ-031 After deassert, INIT SHALL run one LOAD sequence without raising done, then go to IDLE, so hardware and tracked taps agree.
REQ-032 Reset during any state SHALL abort the command; the INIT resync covers the partially moved delay line.

Configuration
REQ-033 With TMDS_DLY_STEP_CNT_EN defined: output step_cnt (16 bits) SHALL count MOVE pulses, saturate at 0xFFFF, and clear on reset and on each cmd_zero LOAD.
REQ-034 Without TMDS_DLY_STEP_CNT_EN: there SHALL be no step_cnt port and no counter logic.

Structure
REQ-035 Package tmds_delay_pkg SHALL hold the state enum, the default TAP_W/LANES constants and MAX_TAP=127.
REQ-036 Sub-module tmds_delay_phase_tmr SHALL provide the HOLD-cycle phase timer (load, count, expire) reused by SETUP/PULSE/RECOVER/LOAD.

Verification (HOLD=2)
REQ-037 Release reset -> loadn=0 for 2 cycles, cmd_ready rises at cycle 5, no done pulse.
REQ-038 Lane 2 target 3 from 0 -> three 2-cycle move[2] pulses, dir=0, done 19 cycles after accept, tap_cur lane2=3.
REQ-039 Lane 0 from 3 to 1 -> dir=1 set 2 cycles before the first pulse, two pulses, done at cycle 13.
REQ-040 Target equal to current -> done at cycle 1 after accept, move stays 0.
REQ-041 cmd_zero after lanes set to 5/7/0/127 -> loadn low 2 cycles, all tap_cur 0, done at cycle 5; cmd_valid held high while busy gets no second accept.
REQ-042 rst_n low mid-PULSE -> move=0 immediately (async), then INIT resync; with TMDS_DLY_STEP_CNT_EN defined, step_cnt=0.

Source files
------------

// File: rtl/tmds_delay_pkg.sv
// tmds_delay_pkg -- shared types and constants for the TMDS DELAYF tap controller.
package tmds_delay_pkg;

  localparam int LANES_DEF = 4;
  localparam int TAP_W_DEF = 7;
  localparam int HOLD_DEF  = 2;
  localparam int MAX_TAP   = 127;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    PULSE   = 3'd3,
    RECOVER = 3'd4,
    LOAD    = 3'd5,
    DONE    = 3'd6
  } state_e;

  // A lane index addresses a real lane only when it is below the lane count.
  function automatic logic lane_valid(input logic [1:0] lane, input int lanes);
    return (int'(lane) < lanes);
  endfunction

endpackage

// File: rtl/tmds_delay_phase_tmr.sv
// tmds_delay_phase_tmr -- HOLD-cycle phase timer. load restarts a phase;
// expire is high in the last cycle of each phase, and the timer reloads
// itself on expiry so back-to-back phases chain without extra cycles.
module tmds_delay_phase_tmr #(
  parameter int HOLD = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expire_o
);

  localparam logic [3:0] RELOAD = 4'(HOLD - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: restart on load or on expiry, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || (cnt_q == 4'd0)) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 4'd0);

endmodule

// File: rtl/tmds_delay_ctrl.sv
// tmds_delay_ctrl -- steps DELAYF tap positions one MOVE pulse at a time and
// tracks the resulting tap of every TMDS lane. Each step is a DIRECTION setup
// phase, a MOVE high phase and a MOVE low phase, each HOLD cycles long.
// Optional feature: define TMDS_DLY_STEP_CNT_EN to add the step_cnt output,
// a saturating count of issued MOVE pulses.
module tmds_delay_ctrl
  import tmds_delay_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int TAP_W = TAP_W_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input  logic                   clk_shift,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_zero,
  input  logic [1:0]             cmd_lane,
  input  logic [TAP_W-1:0]       cmd_tap,
  output logic [LANES-1:0]       move,
  output logic                   loadn,
  output logic                   dir,
`ifdef TMDS_DLY_STEP_CNT_EN
  output logic [15:0]            step_cnt,
`endif
  output logic [LANES*TAP_W-1:0] tap_cur,
  output logic                   done
);

  localparam logic [TAP_W-1:0] TAP_ZERO = {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
  localparam logic [LANES-1:0] MOVE_ONE = LANES'(1);

  state_e           state_q;
  logic [1:0]       lane_q;
  logic [TAP_W-1:0] tgt_q;
  logic [TAP_W-1:0] tap_q [LANES];
  logic [LANES-1:0] move_q;
  logic             loadn_q;
  logic             dir_q;
  logic             done_q;
  logic             ready_q;
  logic             init_q;      // current LOAD sequence is the post-reset resync
  logic             load_rec_q;  // LOAD is in its idle (loadn released) half

  logic [TAP_W-1:0] cmd_tap_cur_s;
  logic [TAP_W-1:0] lane_tap_s;
  logic [TAP_W-1:0] step_tap_s;
  logic             cmd_lane_ok_s;
  logic             accept_s;
  logic             tmr_load_s;
  logic             tmr_expire_s;

  // Look up the tracked tap for the requested lane and for the latched lane.
  always_comb begin
    cmd_tap_cur_s = TAP_ZERO;
    lane_tap_s    = TAP_ZERO;
    for (int i = 0; i < LANES; i++) begin
      cmd_tap_cur_s = (cmd_lane == 2'(i)) ? tap_q[i] : cmd_tap_cur_s;
      lane_tap_s    = (lane_q == 2'(i)) ? tap_q[i] : lane_tap_s;
    end
  end

  assign cmd_lane_ok_s = lane_valid(cmd_lane, LANES);
  assign accept_s      = cmd_valid && ready_q && (state_q == IDLE);
  assign step_tap_s    = dir_q ? (lane_tap_s - TAP_ONE) : (lane_tap_s + TAP_ONE);

  // The timer is held at its reload value outside the timed phases, so the
  // first timed phase after a command or reset gets its full HOLD cycles.
  assign tmr_load_s = (state_q == INIT) || (state_q == IDLE) || (state_q == DONE);

  tmds_delay_phase_tmr #(
    .HOLD (HOLD)
  ) u_phase_tmr (
    .clk_i    (clk_shift),
    .rst_ni   (rst_n),
    .load_i   (tmr_load_s),
    .expire_o (tmr_expire_s)
  );

  // Command sequencer: state, registered DELAYF controls and tracked taps.
  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      lane_q     <= 2'd0;
      tgt_q      <= TAP_ZERO;
      move_q     <= {LANES{1'b0}};
      loadn_q    <= 1'b1;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      init_q     <= 1'b0;
      load_rec_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        tap_q[i] <= TAP_ZERO;
      end
    end else begin
      case (state_q)
        INIT: begin
          // Resync hardware and tracked taps with a silent LOAD sequence.
          state_q    <= LOAD;
          loadn_q    <= 1'b0;
          load_rec_q <= 1'b0;
          init_q     <= 1'b1;
          ready_q    <= 1'b0;
          done_q     <= 1'b0;
          move_q     <= {LANES{1'b0}};
        end
        IDLE: begin
          done_q <= 1'b0;
          if (accept_s) begin
            ready_q <= 1'b0;
            if (cmd_zero) begin
              state_q    <= LOAD;
              loadn_q    <= 1'b0;
              load_rec_q <= 1'b0;
              init_q     <= 1'b0;
            end else if (!cmd_lane_ok_s || (cmd_tap == cmd_tap_cur_s)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              lane_q  <= cmd_lane;
              tgt_q   <= cmd_tap;
              dir_q   <= (cmd_tap < cmd_tap_cur_s);
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          if (tmr_expire_s) begin
            state_q <= PULSE;
            move_q  <= MOVE_ONE << lane_q;
          end
        end
        PULSE: begin
          if (tmr_expire_s) begin
            state_q <= RECOVER;
            move_q  <= {LANES{1'b0}};
          end
        end
        RECOVER: begin
          if (tmr_expire_s) begin
            for (int i = 0; i < LANES; i++) begin
              if (lane_q == 2'(i)) begin
                tap_q[i] <= step_tap_s;
              end
            end
            if (step_tap_s == tgt_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SETUP;
            end
          end
        end
        LOAD: begin
          if (tmr_expire_s) begin
            if (!load_rec_q) begin
              load_rec_q <= 1'b1;
              loadn_q    <= 1'b1;
            end else begin
              load_rec_q <= 1'b0;
              for (int i = 0; i < LANES; i++) begin
                tap_q[i] <= TAP_ZERO;
              end
              if (init_q) begin
                init_q  <= 1'b0;
                state_q <= IDLE;
                ready_q <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT;
          move_q  <= {LANES{1'b0}};
          loadn_q <= 1'b1;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMDS_DLY_STEP_CNT_EN
  logic [15:0] step_cnt_q;

  // Saturating MOVE pulse counter, cleared by every zeroing command.
  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= 16'd0;
    end else if (accept_s && cmd_zero) begin
      step_cnt_q <= 16'd0;
    end else if ((state_q == SETUP) && tmr_expire_s && (step_cnt_q != 16'hFFFF)) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end else begin
      step_cnt_q <= step_cnt_q;
    end
  end

  assign step_cnt = step_cnt_q;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_tap
    assign tap_cur[g*TAP_W +: TAP_W] = tap_q[g];
  end

  assign move      = move_q;
  assign loadn     = loadn_q;
  assign dir       = dir_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_tmds_delay_ctrl.sv
// tb_tmds_delay_ctrl -- scoreboard bench: the driver pushes the expected
// completion of each command, a negedge monitor pops it on every done pulse.
module tb_tmds_delay_ctrl;
  import tmds_delay_pkg::*;

  localparam int LANES = 4;
  localparam int TAP_W = 7;
  localparam int HOLD  = 2;
  localparam int TW    = LANES * TAP_W;

  logic             clk_shift = 1'b0;
  logic             rst_n     = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_zero  = 1'b0;
  logic [1:0]       cmd_lane  = 2'd0;
  logic [TAP_W-1:0] cmd_tap   = 7'd0;
  logic             cmd_ready;
  logic [LANES-1:0] move;
  logic             loadn;
  logic             dir;
  logic             done;
  logic [TW-1:0]    tap_cur;
`ifdef TMDS_DLY_STEP_CNT_EN
  logic [15:0]      step_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;

  typedef struct {
    int            acc;
    int            lat;
    logic [TW-1:0] taps;
    int            pulses;
    logic [LANES-1:0] mask;
    logic          dir;
  } exp_t;

  typedef struct {
    logic             zero;
    logic [1:0]       lane;
    logic [TAP_W-1:0] tap;
    logic             hold;
    int               lat;
    int               pulses;
    logic             dir;
    logic [TAP_W-1:0] t3, t2, t1, t0;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  tmds_delay_ctrl #(.LANES(LANES), .TAP_W(TAP_W), .HOLD(HOLD)) dut (
    .clk_shift (clk_shift),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_zero  (cmd_zero),
    .cmd_lane  (cmd_lane),
    .cmd_tap   (cmd_tap),
    .move      (move),
    .loadn     (loadn),
    .dir       (dir),
`ifdef TMDS_DLY_STEP_CNT_EN
    .step_cnt  (step_cnt),
`endif
    .tap_cur   (tap_cur),
    .done      (done)
  );

  always #5 clk_shift = ~clk_shift;

  always @(posedge clk_shift) begin
    cyc++;
    if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int zero, input int lane, input int tap, input int hold,
                              input int lat, input int pulses, input int d,
                              input int t3, input int t2, input int t1, input int t0);
    vec_t v;
    v.zero = zero[0]; v.lane = lane[1:0]; v.tap = tap[TAP_W-1:0]; v.hold = hold[0];
    v.lat = lat; v.pulses = pulses; v.dir = d[0];
    v.t3 = t3[TAP_W-1:0]; v.t2 = t2[TAP_W-1:0]; v.t1 = t1[TAP_W-1:0]; v.t0 = t0[TAP_W-1:0];
    return v;
  endfunction

  // Monitor state
  int               pulses_seen = 0;
  logic             move_bad = 1'b0;
  logic             dir_bad  = 1'b0;
  logic [LANES-1:0] move_prev = '0;
  logic             dir_h1 = 1'b0;
  logic             dir_h2 = 1'b0;
  exp_t             me;

  always @(negedge clk_shift) begin
    if (!rst_n) begin
      pulses_seen = 0; move_bad = 1'b0; dir_bad = 1'b0; move_prev = '0;
    end else begin
      if (sb_q.size() == 0) begin
        if (move != 4'd0) chk("idle_move", 32'(move), 32'd0);
      end else begin
        if (move != 4'd0 && move != sb_q[0].mask) move_bad = 1'b1;
        if (move != 4'd0 && dir !== sb_q[0].dir) dir_bad = 1'b1;
        if (move != 4'd0 && move_prev == 4'd0) begin
          if (pulses_seen == 0 && dir_h2 !== sb_q[0].dir) dir_bad = 1'b1;
          pulses_seen++;
        end
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sb_q.pop_front();
          chk("latency", 32'(cyc - me.acc + 1), 32'(me.lat));
          chk("tap_cur", 32'(tap_cur), 32'(me.taps));
          chk("pulse_count", 32'(pulses_seen), 32'(me.pulses));
          chk("move_lane_ok", 32'(move_bad), 32'd0);
          if (me.mask != 4'd0) chk("dir_stable", 32'(dir_bad), 32'd0);
        end
        pulses_seen = 0; move_bad = 1'b0; dir_bad = 1'b0;
      end
    end
    move_prev = move;
    dir_h2 = dir_h1;
    dir_h1 = dir;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_move"},    32'(move), 32'd0);
    chk({tag, "_loadn"},   32'(loadn), 32'd1);
    chk({tag, "_dir"},     32'(dir), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
    chk({tag, "_ready"},   32'(cmd_ready), 32'd0);
    chk({tag, "_tap_cur"}, 32'(tap_cur), 32'd0);
`ifdef TMDS_DLY_STEP_CNT_EN
    chk({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
`endif
  endtask

  // Release reset and watch the silent resync LOAD sequence.
  task automatic release_and_init();
    int low_cnt, rdy_at, done_cnt;
    low_cnt = 0; rdy_at = 0; done_cnt = 0;
    @(negedge clk_shift); #1 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk_shift); #1;
      if (loadn === 1'b0) low_cnt++;
      if (cmd_ready === 1'b1 && rdy_at == 0) rdy_at = e;
      if (done === 1'b1) done_cnt++;
    end
    chk("init_loadn_low_cycles", 32'(low_cnt), 32'd2);
    chk("init_ready_cycle", 32'(rdy_at), 32'd5);
    chk("init_done_pulses", 32'(done_cnt), 32'd0);
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    int   w, acc0;
    w = 0;
    @(negedge clk_shift);
    while (cmd_ready !== 1'b1 && w < 2000) begin
      @(negedge clk_shift);
      w++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) return;
    e.acc    = cyc + 1;
    e.lat    = v.lat;
    e.taps   = {v.t3, v.t2, v.t1, v.t0};
    e.pulses = v.pulses;
    e.mask   = (v.zero || v.pulses == 0) ? 4'd0 : (4'b0001 << v.lane);
    e.dir    = v.dir;
    sb_q.push_back(e);
    acc0 = acc_cnt;
    cmd_valid = 1'b1; cmd_zero = v.zero; cmd_lane = v.lane; cmd_tap = v.tap;
    @(posedge clk_shift); #1;
    if (v.hold) begin
      w = 0;
      while (done !== 1'b1 && w < 2000) begin
        @(negedge clk_shift);
        w++;
      end
      chk("held_done_seen", 32'(done), 32'd1);
      cmd_valid = 1'b0;
      chk("held_single_accept", 32'(acc_cnt - acc0), 32'd1);
    end else begin
      cmd_valid = 1'b0;
    end
    cmd_zero = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    //            zero lane tap      hold lat  pul dir  t3       t2 t1 t0
    vecs[0]  = mk(0, 2, 3,       0, 19,  3,  0,   0,       3, 0, 0);
    vecs[1]  = mk(0, 0, 3,       0, 19,  3,  0,   0,       3, 0, 3);
    vecs[2]  = mk(0, 0, 1,       0, 13,  2,  1,   0,       3, 0, 1);
    vecs[3]  = mk(0, 0, 1,       0, 1,   0,  0,   0,       3, 0, 1);
    vecs[4]  = mk(0, 0, 5,       0, 25,  4,  0,   0,       3, 0, 5);
    vecs[5]  = mk(0, 1, 7,       0, 43,  7,  0,   0,       3, 7, 5);
    vecs[6]  = mk(0, 2, 0,       0, 19,  3,  1,   0,       0, 7, 5);
    vecs[7]  = mk(0, 3, MAX_TAP, 0, 763, 127, 0,  MAX_TAP, 0, 7, 5);
    vecs[8]  = mk(0, 3, 126,     0, 7,   1,  1,   126,     0, 7, 5);
    vecs[9]  = mk(0, 3, MAX_TAP, 0, 7,   1,  0,   MAX_TAP, 0, 7, 5);
    vecs[10] = mk(1, 2, 9,       1, 5,   0,  0,   0,       0, 0, 0);
    vecs[11] = mk(0, 1, 0,       0, 1,   0,  0,   0,       0, 0, 0);

    #1 rst_n = 1'b0;
    #20;
    check_reset_vals("reset");
    release_and_init();

    foreach (vecs[i]) issue(vecs[i]);

    // Abort a command in the middle of a MOVE pulse.
    issue(mk(0, 1, 2, 0, 13, 2, 0, 0, 0, 2, 0));
    w = 0;
    while (move === 4'd0 && w < 100) begin
      @(negedge clk_shift);
      w++;
    end
    chk("pulse_reached", 32'(move), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    sb_q.delete();
    release_and_init();

    issue(mk(0, 1, 1, 0, 7, 1, 0, 0, 0, 1, 0));

    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk_shift);
      w++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk_shift);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
